// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Two-word window: TXDATA (+0) pushes a byte, STATUS (+4) reports FIFO/shifter.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write_enab,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        hit,
   output logic        tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [PW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;

   logic sel_data, sel_stat;
   logic push, push_ok, pop, clr;
   logic empty, full, busy, last;
   logic unused_bits;

   assign hit      = (data_addr[31:3] == BASE_ADDR[31:3]);
   assign sel_data = hit & ~data_addr[2];
   assign sel_stat = hit & data_addr[2];
   assign push     = write_enab & sel_data;
   assign clr      = write_enab & sel_stat & write_data[3];
   assign empty    = (count_q == '0);
   assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
   assign busy     = (state_q != IDLE);
   assign last     = (cnt_q == CW'(CLKS_PER_BIT - 1));
   // a pop in the same cycle frees the slot a full FIFO would refuse
   assign push_ok  = push & (~full | pop);
   assign tx       = tx_q;

   assign read_data = sel_stat ? {28'd0, ovf_q, busy, empty, full} : '0;
   assign unused_bits = ^{write_data[31:8], data_addr[1:0]};

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop)     rptr_d = rptr_q + 1'b1;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (clr)             ovf_d = 1'b0;
      if (push & ~push_ok) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= write_data[7:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (last) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (last) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // chain straight into the next START to avoid an idle gap
            if (last) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[idx_d];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register window, framing, FIFO, reset.
// A background receiver captures every frame cycle by cycle.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE   = 32'hFFFF_0000;
   localparam logic [31:0] DATA_A = BASE;
   localparam logic [31:0] STAT_A = BASE + 32'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        write_enab = 1'b0;
   logic [31:0] data_addr = STAT_A;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        hit;
   logic        tx;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [39:0] frames [$];
   int          starts [$];

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .write_enab(write_enab),
      .data_addr (data_addr),
      .write_data(write_data),
      .read_data (read_data),
      .hit       (hit),
      .tx        (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] expf(input logic [7:0] b);
      logic [39:0] v;
      for (int k = 0; k < 40; k++) begin
         int p;
         p = k / 4;
         if (p == 0)      v[k] = 1'b0;
         else if (p == 9) v[k] = 1'b1;
         else             v[k] = b[p-1];
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      write_enab = 1'b1;
      data_addr  = a;
      write_data = d;
      tick();
      write_enab = 1'b0;
      data_addr  = STAT_A;
      write_data = '0;
   endtask

   task automatic rd(output logic [31:0] v);
      data_addr = STAT_A;
      #1;
      v = read_data;
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      int i;
      i = 0;
      while (frames.size() < n && i < budget) begin
         tick();
         i++;
      end
      check(tag, frames.size(), n);
   endtask

   task automatic check_burst(input string tag, input int n, input int s0);
      for (int k = 0; k < n && k < frames.size(); k++) begin
         check($sformatf("%s_frame%0d", tag, k), frames[k],
               expf(8'h41 + 8'(k)));
         if (k == 0) check($sformatf("%s_start", tag), starts[0], s0 + 1);
         else check($sformatf("%s_gap%0d", tag, k),
                    starts[k] - starts[k-1], 40);
      end
   endtask

   initial begin : rx
      logic [39:0] v;
      int s;
      forever begin
         @(posedge clk);
         #2;
         if (tx === 1'b0) begin
            s    = cyc;
            v    = '0;
            v[0] = tx;
            for (int k = 1; k < 40; k++) begin
               @(posedge clk);
               #2;
               v[k] = tx;
            end
            frames.push_back(v);
            starts.push_back(s);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] v;
      int sn, nb, lows, s0;

      repeat (3) tick();
      reset = 1'b0;
      check("rst_tx", tx, 1);
      rd(v);
      check("rst_status", v, 32'h2);
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         lows += (tx === 1'b0) ? 1 : 0;
         tick();
      end
      check("idle_tx_low_cycles", lows, 0);
      rd(v);
      check("idle_status", v, 32'h2);

      frames.delete();
      starts.delete();
      store(DATA_A, 32'h0000_0055);
      sn = cyc;
      rd(v);
      check("push_status", v, 32'h0);
      check("push_tx_still_high", tx, 1);
      nb = 0;
      for (int i = 0; i < 50; i++) begin
         rd(v);
         nb += v[2] ? 1 : 0;
         tick();
      end
      check("busy_cycles", nb, 40);
      check("f55_count", frames.size(), 1);
      if (frames.size() >= 1) begin
         check("f55_bits", frames[0], expf(8'h55));
         check("f55_start", starts[0], sn + 1);
      end

      frames.delete();
      starts.delete();
      s0 = cyc + 1;
      for (int b = 0; b < 5; b++) store(DATA_A, 32'h41 + b);
      rd(v);
      check("five_status", v, 32'h5);
      wait_frames("five_count", 5, 400);
      check_burst("five", 5, s0);
      repeat (10) tick();

      frames.delete();
      starts.delete();
      s0 = cyc + 1;
      for (int b = 0; b < 6; b++) store(DATA_A, 32'h41 + b);
      rd(v);
      check("six_status_ovf", v, 32'hD);
      store(STAT_A, 32'h8);
      rd(v);
      check("ovf_clear_status", v, 32'h5);
      wait_frames("six_count", 5, 400);
      repeat (60) tick();
      check("six_no_extra", frames.size(), 5);
      check_burst("six", 5, s0);
      rd(v);
      check("six_end_status", v, 32'h2);

      frames.delete();
      starts.delete();
      write_enab = 1'b1;
      write_data = 32'h99;
      data_addr  = BASE + 32'd8;
      #1;
      check("above_hit", hit, 0);
      check("above_rdata", read_data, 0);
      tick();
      data_addr = BASE - 32'd4;
      #1;
      check("below_hit", hit, 0);
      check("below_rdata", read_data, 0);
      tick();
      write_enab = 1'b0;
      data_addr  = DATA_A;
      #1;
      check("txdata_hit", hit, 1);
      check("txdata_rdata", read_data, 0);
      data_addr = BASE + 32'd6;
      #1;
      check("status_lowbits", read_data, 32'h2);
      repeat (60) tick();
      check("nohit_no_frame", frames.size(), 0);

      frames.delete();
      starts.delete();
      store(DATA_A, 32'h55);
      store(DATA_A, 32'h33);
      repeat (12) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_tx", tx, 1);
      rd(v);
      check("midrst_status", v, 32'h2);
      repeat (60) tick();
      frames.delete();
      starts.delete();
      repeat (100) tick();
      check("midrst_no_frame", frames.size(), 0);
      check("midrst_tx_idle", tx, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory bus, downstream of the single-cycle core's store path. It consumes the core's `write_enab` / `data_addr` / `write_data` store outputs and decodes a two-word register window at `BASE_ADDR`. Stored bytes are queued in a small FIFO and serialised as 8N1 frames on `tx`. A status word is returned for loads that hit the window.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_0000: word-aligned base of the register window.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: system clock. Only clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `write_enab`  in  1: store strobe from the core.
- `data_addr`  in  32: load/store byte address.
- `write_data`  in  32: store data.
- `read_data`  out  32: combinational load data for a window hit; 0 otherwise.
- `hit`  out  1: combinational; `data_addr` lies in [BASE_ADDR, BASE_ADDR+7]. Used by the board-level read mux.
- `tx`  out  1: serial line; idle high.

## Operation
Address decode uses `data_addr[31:3] == BASE_ADDR[31:3]`. Bits [1:0] are ignored.

Registers:
- TXDATA at +0.
  - Store: push `write_data[7:0]`.
  - Load: returns 0.
- STATUS at +4, load layout:
  - bit0 full.
  - bit1 empty.
  - bit2 busy: shifter not IDLE.
  - bit3 overflow: sticky.
  - bits[31:4] = 0.
  - Store: writing 1 to bit3 clears overflow. Other bits are ignored.

FIFO:
- Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
- A push that is not accepted is dropped and sets overflow on that edge.
- If a clear-overflow store and a dropped push coincide, overflow is set. This cannot happen in a single cycle, since they are different addresses; the rule is documented for completeness.

Shifter FSM, with a bit-period counter (0..CLKS_PER_BIT-1) and a bit index (0..7):
- IDLE: tx=1. If FIFO not empty, pop the head into the shift register, clear the counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA: tx = shift[index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
  - if the FIFO is non-empty, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- `tx` is a registered output, driven from state and shift register.

Reset values: state IDLE, `tx`=1, count=0, pointers=0, overflow=0, counters=0. `read_data` and `hit` are combinational and have no reset value.

## Timing
- A store to TXDATA sampled at edge N with the FIFO empty and shifter IDLE:
  - entry is visible (empty=0) after edge N;
  - pop at edge N+1;
  - `tx` falls after edge N+1;
  - frame occupies exactly 10·CLKS_PER_BIT cycles.
- STATUS loads reflect state registered at the most recent edge. A push at edge N is visible to a load in cycle N+1.
- Back-to-back frames: STOP's final cycle is followed immediately by START of the next byte.
- Reset asserted at any point, including mid-frame: all state returns to reset values at that edge. `tx`=1 in the following cycle, the frame is truncated, and FIFO contents are discarded.
- `write_enab` with a non-hitting address has no effect.
- A load-only access (`write_enab`=0) never changes state.

## Test plan
- Reset, then idle 50 cycles → `tx`=1 throughout; STATUS load returns 32'h0000_0002.
- CLKS_PER_BIT=4, store 32'h0000_0055 to TXDATA at edge N → `tx` low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. busy=1 for 40 cycles.
- Five TXDATA stores on consecutive cycles (0x41..0x45), FIFO_DEPTH=4:
  - the first pops at cycle 2, so all five are accepted and overflow=0;
  - repeat with six stores → sixth (0x46) dropped, STATUS bit3=1;
  - output frames are 0x41..0x45 with no idle gaps.
- Store 32'h8 to STATUS after overflow → STATUS bit3=0 next cycle; FIFO and frames unaffected.
- Store to BASE_ADDR+8 and to BASE_ADDR-4 → `hit`=0, no push, `read_data`=0.
- Assert reset for one cycle at cycle 13 of a frame → `tx`=1 the next cycle, STATUS=32'h2, no further frames.
